// File: rtl/cpu_complex_sequencer_pkg.sv
// Shared CPU defines for the complex (RV32M) execution path: operation and
// sequencer state encodings plus small decode helpers used by execute,
// decoder and the sequencer itself.
package cpu_complex_sequencer_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } complex_op_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MUL_WAIT = 2'd1,
        ST_DIV_WAIT = 2'd2,
        ST_DONE     = 2'd3
    } complex_state_t;

    localparam logic [31:0] INT_MIN_32  = 32'h8000_0000;
    localparam logic [31:0] ALL_ONES_32 = 32'hFFFF_FFFF;

    // Divide-family ops occupy the upper half of the encoding.
    function automatic logic op_is_div(complex_op_t op);
        return op[2];
    endfunction

    // REM and REMU return the remainder instead of the quotient.
    function automatic logic op_is_rem(complex_op_t op);
        return op[2] & op[1];
    endfunction

    function automatic logic op_is_signed_div(complex_op_t op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/cpu_complex_sequencer_div_special.sv
// Divide special-case detector. Recognises divide-by-zero and signed
// overflow (INT_MIN / -1) so the sequencer can answer without the divider.
module cpu_div_special
    import cpu_complex_sequencer_pkg::*;
(
    input  complex_op_t op,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    output logic        hit,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    logic div_by_zero;
    logic overflow;

    // Classify the request and produce the architecturally defined results.
    always_comb begin
        div_by_zero = (rs2 == '0);
        overflow    = op_is_signed_div(op) && (rs1 == INT_MIN_32) && (rs2 == ALL_ONES_32);
        hit         = op_is_div(op) && (div_by_zero || overflow);
        if (div_by_zero) begin
            quotient  = ALL_ONES_32;
            remainder = rs1;
        end else begin
            quotient  = INT_MIN_32;
            remainder = '0;
        end
    end

endmodule

// File: rtl/cpu_complex_sequencer.sv
// Sequencer for the shared multiplier and divider. Accepts one operation at
// a time, latches operands, starts the right unit, waits its fixed latency
// and returns the selected result with the request tag as a done pulse.
module cpu_complex_sequencer
    import cpu_complex_sequencer_pkg::*;
#(
    parameter int MUL_LATENCY = 3,
    parameter int DIV_LATENCY = 8,
    parameter int TAG_WIDTH   = 8
) (
    input  logic                 i_clock,
    input  logic                 i_reset_n,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  complex_op_t          i_op,
    input  logic [31:0]          i_rs1,
    input  logic [31:0]          i_rs2,
    input  logic [TAG_WIDTH-1:0] i_tag,
    input  logic                 i_flush,
    output logic                 o_done,
    output logic [31:0]          o_result,
    output logic [TAG_WIDTH-1:0] o_tag,
    output logic                 o_mul_latch,
    output logic                 o_mul_signed1,
    output logic                 o_mul_signed2,
    input  logic [63:0]          i_mul_result,
    output logic                 o_div_latch,
    output logic                 o_div_signed,
    input  logic [31:0]          i_div_result,
    input  logic [31:0]          i_div_remainder,
    output logic [31:0]          o_op1,
    output logic [31:0]          o_op2
);

    localparam logic [3:0] MUL_LAT = 4'(MUL_LATENCY);
    localparam logic [3:0] DIV_LAT = 4'(DIV_LATENCY);

    complex_state_t       state_q;
    complex_state_t       state_d;
    complex_op_t          op_q;
    logic [TAG_WIDTH-1:0] tag_q;
    logic [3:0]           count_q;

    logic        accept;
    logic        special_hit;
    logic [31:0] special_quotient;
    logic [31:0] special_remainder;
    logic        mul_finish;
    logic        div_finish;
    logic [31:0] mul_sel;
    logic [31:0] div_sel;

    // Special cases are judged on the live request so they can finish in
    // the cycle right after accept; operands are only valid at accept.
    cpu_div_special u_div_special (
        .op        (i_op),
        .rs1       (i_rs1),
        .rs2       (i_rs2),
        .hit       (special_hit),
        .quotient  (special_quotient),
        .remainder (special_remainder)
    );

    // Handshake, completion strobes and result selection.
    always_comb begin
        accept     = i_valid && o_ready && !i_flush;
        mul_finish = (state_q == ST_MUL_WAIT) && (count_q == MUL_LAT) && !i_flush;
        div_finish = (state_q == ST_DIV_WAIT) && (count_q == DIV_LAT) && !i_flush;
        mul_sel    = (op_q == OP_MUL) ? i_mul_result[31:0] : i_mul_result[63:32];
        div_sel    = op_is_rem(op_q) ? i_div_remainder : i_div_result;
    end

    // State register.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (!i_reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush overrides everything.
    always_comb begin
        // NOTE: default first so no path leaves state_d unassigned (no latch).
        state_d = state_q;
        if (i_flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        if (!op_is_div(i_op)) begin
                            state_d = ST_MUL_WAIT;
                        end else if (special_hit) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_DIV_WAIT;
                        end
                    end
                end
                ST_MUL_WAIT: if (count_q == MUL_LAT) state_d = ST_DONE;
                ST_DIV_WAIT: if (count_q == DIV_LAT) state_d = ST_DONE;
                ST_DONE:     state_d = ST_IDLE;
                default:     state_d = ST_IDLE;
            endcase
        end
    end

    // Outputs decoded from the current state; flush kills pulses in-cycle.
    always_comb begin
        o_mul_latch = (state_q == ST_MUL_WAIT) && (count_q == '0) && !i_flush;
        o_div_latch = (state_q == ST_DIV_WAIT) && (count_q == '0) && !i_flush;
        o_done      = (state_q == ST_DONE) && !i_flush;
    end

    // Ready flag and wait counter track the state being entered.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_ready <= 1'b0;
            count_q <= '0;
        end else begin
            o_ready <= (state_d == ST_IDLE);
            if ((state_q == state_d) &&
                ((state_q == ST_MUL_WAIT) || (state_q == ST_DIV_WAIT))) begin
                count_q <= count_q + 4'd1;
            end else begin
                count_q <= '0;
            end
        end
    end

    // Operand, tag and signedness capture at accept.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            op_q          <= OP_MUL;
            tag_q         <= '0;
            o_op1         <= '0;
            o_op2         <= '0;
            o_mul_signed1 <= 1'b0;
            o_mul_signed2 <= 1'b0;
            o_div_signed  <= 1'b0;
        end else if (accept) begin
            op_q          <= i_op;
            tag_q         <= i_tag;
            o_op1         <= i_rs1;
            o_op2         <= i_rs2;
            o_mul_signed1 <= (i_op == OP_MUL) || (i_op == OP_MULH) || (i_op == OP_MULHSU);
            o_mul_signed2 <= (i_op == OP_MUL) || (i_op == OP_MULH);
            o_div_signed  <= op_is_signed_div(i_op);
        end
    end

    // Result and tag registers, updated only on a completion.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_result <= '0;
            o_tag    <= '0;
        end else if (accept && special_hit) begin
            o_result <= op_is_rem(i_op) ? special_remainder : special_quotient;
            o_tag    <= i_tag;
        end else if (mul_finish) begin
            o_result <= mul_sel;
            o_tag    <= tag_q;
        end else if (div_finish) begin
            o_result <= div_sel;
            o_tag    <= tag_q;
        end
    end

endmodule

// File: tb/tb_cpu_complex_sequencer.sv
// Self-checking bench for cpu_complex_sequencer: behavioural unit models,
// a cycle-level transaction model and a per-cycle compare process.
module tb_cpu_complex_sequencer;
    import cpu_complex_sequencer_pkg::*;

    localparam int MUL_LAT = 3;
    localparam int DIV_LAT = 8;
    localparam int TW      = 8;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          valid = 1'b0;
    complex_op_t   op    = OP_MUL;
    logic [31:0]   rs1   = '0;
    logic [31:0]   rs2   = '0;
    logic [TW-1:0] tag   = '0;
    logic          flush = 1'b0;
    logic [63:0]   mul_result = '0;
    logic [31:0]   div_result = '0;
    logic [31:0]   div_rem    = '0;

    logic          o_ready, o_done, o_mul_latch, o_mul_signed1, o_mul_signed2;
    logic          o_div_latch, o_div_signed;
    logic [31:0]   o_result, o_op1, o_op2;
    logic [TW-1:0] o_tag;

    always #5 clk = ~clk;

    cpu_complex_sequencer #(
        .MUL_LATENCY(MUL_LAT), .DIV_LATENCY(DIV_LAT), .TAG_WIDTH(TW)
    ) dut (
        .i_clock(clk), .i_reset_n(rst_n), .i_valid(valid), .o_ready(o_ready),
        .i_op(op), .i_rs1(rs1), .i_rs2(rs2), .i_tag(tag), .i_flush(flush),
        .o_done(o_done), .o_result(o_result), .o_tag(o_tag),
        .o_mul_latch(o_mul_latch), .o_mul_signed1(o_mul_signed1),
        .o_mul_signed2(o_mul_signed2), .i_mul_result(mul_result),
        .o_div_latch(o_div_latch), .o_div_signed(o_div_signed),
        .i_div_result(div_result), .i_div_remainder(div_rem),
        .o_op1(o_op1), .o_op2(o_op2)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Architectural RV32M result, straight from the ISA definition.
    function automatic logic [31:0] ref_result(complex_op_t o, logic [31:0] a, logic [31:0] b);
        longint sa, sb, ub;
        longint unsigned ua64, ub64;
        logic [63:0] p;
        int ia, ib;
        logic [31:0] r;
        sa = longint'($signed(a)); sb = longint'($signed(b)); ub = longint'({32'b0, b});
        ua64 = {32'b0, a}; ub64 = {32'b0, b};
        ia = $signed(a); ib = $signed(b);
        r = '0;
        case (o)
            OP_MUL:    begin p = 64'(sa * sb);     r = p[31:0];  end
            OP_MULH:   begin p = 64'(sa * sb);     r = p[63:32]; end
            OP_MULHSU: begin p = 64'(sa * ub);     r = p[63:32]; end
            OP_MULHU:  begin p = 64'(ua64 * ub64); r = p[63:32]; end
            OP_DIV:    r = (b == 0) ? 32'hFFFFFFFF :
                           (a == 32'h80000000 && b == 32'hFFFFFFFF) ? 32'h80000000 : 32'(ia / ib);
            OP_DIVU:   r = (b == 0) ? 32'hFFFFFFFF : a / b;
            OP_REM:    r = (b == 0) ? a :
                           (a == 32'h80000000 && b == 32'hFFFFFFFF) ? 32'h0 : 32'(ia % ib);
            OP_REMU:   r = (b == 0) ? a : a % b;
            default:   r = '0;
        endcase
        return r;
    endfunction

    function automatic bit ref_special(complex_op_t o, logic [31:0] a, logic [31:0] b);
        return o[2] && ((b == 0) ||
               ((o == OP_DIV || o == OP_REM) && a == 32'h80000000 && b == 32'hFFFFFFFF));
    endfunction

    // Multiplier / divider behavioural models: random output until LATENCY
    // cycles after the latch pulse, then the true answer held.
    logic [63:0] mul_prod_q;
    logic [31:0] div_q_q, div_r_q;
    bit          mul_have = 0, div_have = 0;
    int          mul_elapsed = 0, div_elapsed = 0;

    always @(negedge clk) begin
        logic [63:0] ea, eb;
        if (o_mul_latch) begin
            ea = o_mul_signed1 ? {{32{o_op1[31]}}, o_op1} : {32'b0, o_op1};
            eb = o_mul_signed2 ? {{32{o_op2[31]}}, o_op2} : {32'b0, o_op2};
            mul_prod_q = ea * eb;
            mul_have = 1; mul_elapsed = 0;
        end else if (mul_elapsed < 1000) begin
            mul_elapsed++;
        end
        if (o_div_latch) begin
            if (o_op2 == 0 || (o_div_signed && o_op1 == 32'h80000000 && o_op2 == 32'hFFFFFFFF)) begin
                div_q_q = $urandom; div_r_q = $urandom;
            end else if (o_div_signed) begin
                div_q_q = 32'($signed(o_op1) / $signed(o_op2));
                div_r_q = 32'($signed(o_op1) % $signed(o_op2));
            end else begin
                div_q_q = o_op1 / o_op2;
                div_r_q = o_op1 % o_op2;
            end
            div_have = 1; div_elapsed = 0;
        end else if (div_elapsed < 1000) begin
            div_elapsed++;
        end
        mul_result = (mul_have && mul_elapsed >= MUL_LAT) ? mul_prod_q : {$urandom, $urandom};
        div_result = (div_have && div_elapsed >= DIV_LAT) ? div_q_q : $urandom;
        div_rem    = (div_have && div_elapsed >= DIV_LAT) ? div_r_q : $urandom;
    end

    // Transaction model state and observations used by directed pins.
    bit            m_busy = 0, m_is_mul = 0, m_special = 0;
    int            ready_at = 0, m_latch_cyc = 0, m_done_cyc = 0;
    complex_op_t   m_op = OP_MUL;
    logic [31:0]   m_rs1 = '0, m_rs2 = '0, m_res = '0;
    logic [TW-1:0] m_tag = '0;
    int            done_count = 0, mul_latch_count = 0, div_latch_count = 0;
    int            last_accept_cyc = 0, last_done_cyc = 0;
    logic [31:0]   last_res = '0;
    logic [TW-1:0] last_tag = '0;
    logic          last_s1 = 0, last_s2 = 0;

    // Compare process: checks every cycle, then advances the model across
    // the clock edge that ends this cycle.
    always @(negedge clk) begin
        bit e_ready, e_done, e_mlat, e_dlat;
        cyc++;
        e_ready = rst_n && !m_busy && (cyc >= ready_at);
        e_done  = rst_n && m_busy && (cyc == m_done_cyc) && !flush;
        e_mlat  = rst_n && m_busy && m_is_mul && (cyc == m_latch_cyc) && !flush;
        e_dlat  = rst_n && m_busy && !m_is_mul && !m_special && (cyc == m_latch_cyc) && !flush;
        check("ready", o_ready, e_ready);
        check("done", o_done, e_done);
        check("mul_latch", o_mul_latch, e_mlat);
        check("div_latch", o_div_latch, e_dlat);
        if (e_done) begin
            check("result", o_result, m_res);
            check("tag", o_tag, m_tag);
        end
        if (e_mlat || e_dlat) begin
            check("op1", o_op1, m_rs1);
            check("op2", o_op2, m_rs2);
        end
        if (e_mlat) begin
            check("mul_signed1", o_mul_signed1, m_op != OP_MULHU);
            check("mul_signed2", o_mul_signed2, (m_op == OP_MUL) || (m_op == OP_MULH));
        end
        if (e_dlat) check("div_signed", o_div_signed, (m_op == OP_DIV) || (m_op == OP_REM));
        if (!rst_n) begin
            check("rst_op1", o_op1, 0);
            check("rst_op2", o_op2, 0);
            check("rst_res_tag_flags", {o_result, o_tag, o_mul_signed1, o_mul_signed2, o_div_signed}, 0);
        end
        if (o_done) begin done_count++; last_res = o_result; last_tag = o_tag; last_done_cyc = cyc; end
        if (o_mul_latch) begin mul_latch_count++; last_s1 = o_mul_signed1; last_s2 = o_mul_signed2; end
        if (o_div_latch) div_latch_count++;

        if (!rst_n) begin
            m_busy = 0; ready_at = cyc + 2;
        end else if (m_busy) begin
            if (flush || cyc == m_done_cyc) begin m_busy = 0; ready_at = cyc + 1; end
        end else if (e_ready && valid && !flush) begin
            m_busy = 1; m_op = op; m_rs1 = rs1; m_rs2 = rs2; m_tag = tag;
            m_is_mul = !op[2];
            m_special = ref_special(op, rs1, rs2);
            m_res = ref_result(op, rs1, rs2);
            m_latch_cyc = cyc + 1;
            m_done_cyc = m_special ? cyc + 1 : cyc + (m_is_mul ? MUL_LAT : DIV_LAT) + 2;
            last_accept_cyc = cyc;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(string name);
        int n = 0;
        while (!o_ready && n < 50) begin tick(); n++; end
        check(name, o_ready, 1);
    endtask

    task automatic issue(complex_op_t o, logic [31:0] a, logic [31:0] b, logic [TW-1:0] t);
        wait_ready("issue_wait");
        op = o; rs1 = a; rs2 = b; tag = t; valid = 1;
        tick();
        valid = 0; rs1 = $urandom; rs2 = $urandom;
    endtask

    // Issue one op, wait for completion and pin result and latency.
    task automatic run_pin(string name, complex_op_t o, logic [31:0] a, logic [31:0] b,
                           logic [TW-1:0] t, logic [31:0] want, int lat);
        int d0;
        d0 = done_count;
        issue(o, a, b, t);
        wait_ready({name, "_idle"});
        check({name, "_result"}, last_res, want);
        check({name, "_tag"}, last_tag, t);
        check({name, "_latency"}, last_done_cyc - last_accept_cyc, lat);
        check({name, "_one_done"}, done_count - d0, 1);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h80000000;
            2: return 32'hFFFFFFFF;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int d0, m0, v0;
        repeat (3) tick();
        rst_n = 1;
        tick();
        check("ready_after_reset", o_ready, 1);

        m0 = mul_latch_count;
        run_pin("mul", OP_MUL, 32'hFFFFFFFE, 32'd3, 8'h11, 32'hFFFFFFFA, 5);
        check("mul_latch_once", mul_latch_count - m0, 1);
        check("mul_signed_flags", {last_s1, last_s2}, 2'b11);
        run_pin("mulhu", OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 8'h22, 32'hFFFFFFFE, 5);
        run_pin("mulhsu", OP_MULHSU, 32'hFFFFFFFF, 32'd2, 8'h23, 32'hFFFFFFFF, 5);
        check("mulhsu_signed_flags", {last_s1, last_s2}, 2'b10);

        v0 = div_latch_count;
        run_pin("div_by_zero", OP_DIV, 32'd7, 32'd0, 8'h33, 32'hFFFFFFFF, 1);
        run_pin("rem_overflow", OP_REM, 32'h80000000, 32'hFFFFFFFF, 8'h34, 32'h0, 1);
        check("special_no_div_latch", div_latch_count - v0, 0);
        run_pin("divu", OP_DIVU, 32'd100, 32'd7, 8'h44, 32'd14, 10);
        run_pin("remu", OP_REMU, 32'd100, 32'd7, 8'h45, 32'd2, 10);
        run_pin("div_neg", OP_DIV, 32'hFFFFFF9C, 32'd7, 8'h46, 32'hFFFFFFF2, 10);

        // Flush in cycle 4 of a divide, new multiply accepted in cycle 5.
        d0 = done_count;
        issue(OP_DIV, 32'd1000, 32'd3, 8'h55);
        repeat (3) tick();
        flush = 1;
        tick();
        flush = 0;
        check("flush_ready_c5", o_ready, 1);
        check("flush_no_done", done_count - d0, 0);
        run_pin("mul_after_flush", OP_MUL, 32'd5, 32'd6, 8'h66, 32'd30, 5);

        // Async reset during MUL_WAIT.
        issue(OP_MULH, 32'h12345678, 32'h9ABCDEF0, 8'h77);
        tick();
        rst_n = 0;
        #1;
        check("rst_async_ctrl", {o_ready, o_done, o_mul_latch, o_div_latch,
                                 o_mul_signed1, o_mul_signed2, o_div_signed}, 0);
        check("rst_async_ops", {o_op1, o_op2}, 0);
        check("rst_async_res", {o_result, o_tag}, 0);
        d0 = done_count;
        tick();
        rst_n = 1;
        #1;
        check("rst_ready_still_low", o_ready, 0);
        tick();
        check("rst_ready_after_edge", o_ready, 1);
        repeat (12) tick();
        check("rst_no_stale_done", done_count - d0, 0);

        // Randomized traffic with occasional flushes.
        d0 = done_count;
        for (int i = 0; i < 3000; i++) begin
            valid = ($urandom_range(0, 2) != 0);
            op    = complex_op_t'($urandom_range(0, 7));
            rs1   = pick_operand();
            rs2   = pick_operand();
            tag   = TW'($urandom);
            flush = ($urandom_range(0, 24) == 0);
            tick();
        end
        valid = 0; flush = 0;
        wait_ready("final_idle");
        check("random_progress", done_count - d0 > 50, 1);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
